// File: rtl/top_submap_decoder.sv
// top_submap_decoder: host strobe demux onto N_SLOTS submaps; define TOP_SUBMAP_DECODER_TIMEOUT_EN to error on slots that never ack
module top_submap_decoder #(
    parameter int N_SLOTS = 5,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [ADDR_W-1:0]         h_adr_i,
    input  logic [DATA_W-1:0]         h_dat_i,
    input  logic                      h_wr_i,
    input  logic                      h_rd_i,
    output logic [DATA_W-1:0]         h_dat_o,
    output logic                      h_ack_o,
    output logic                      h_err_o,
    output logic                      h_busy_o,
    output logic [N_SLOTS-1:0]        s_wr_o,
    output logic [N_SLOTS-1:0]        s_rd_o,
    output logic [DATA_W-1:0]         s_dat_o,
    input  logic [N_SLOTS*DATA_W-1:0] s_dat_i,
    input  logic [N_SLOTS-1:0]        s_ack_i
);
    localparam int IW = ADDR_W - 2;
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
    logic [1:0]         state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d, adr_idx;
    logic               wr_q, wr_d, ack_q, ack_d, err_q, err_d;
    logic [DATA_W-1:0]  wdat_q, wdat_d, rdat_q, rdat_d;
    logic [N_SLOTS-1:0] srd_q, srd_d, swr_q, swr_d, onehot;
    logic               hit, unused_bits;
    assign adr_idx     = h_adr_i[ADDR_W-1:2];
    assign onehot      = N_SLOTS'(1) << adr_idx;
    assign hit         = (h_rd_i ^ h_wr_i) && int'(adr_idx) < N_SLOTS;
    assign unused_bits = ^{h_adr_i[1:0], TIMEOUT};
`ifdef TOP_SUBMAP_DECODER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1) > 8 ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo;
    assign cnt_d = state_q == IDLE ? '0 : cnt_q + 1'b1;
    assign tmo   = cnt_q == CW'(TIMEOUT - 1);
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
`endif
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        srd_d   = '0;
        swr_d   = '0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        if (state_q == IDLE && (h_rd_i || h_wr_i)) begin
            state_d = hit ? WAIT : RESP;
            err_d   = !hit;
            if (hit) begin
                idx_d  = adr_idx;
                wr_d   = h_wr_i;
                wdat_d = h_dat_i;
                srd_d  = h_rd_i ? onehot : '0;
                swr_d  = h_wr_i ? onehot : '0;
            end
        end else if (state_q == WAIT && s_ack_i[idx_q]) begin
            state_d = RESP;
            ack_d   = 1'b1;
            rdat_d  = wr_q ? rdat_q : s_dat_i[idx_q*DATA_W +: DATA_W];
        end
`ifdef TOP_SUBMAP_DECODER_TIMEOUT_EN
        else if (state_q == WAIT && tmo) begin
            state_d = RESP;
            err_d   = 1'b1;
        end
`endif
        else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            srd_q   <= '0;
            swr_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            srd_q   <= srd_d;
            swr_q   <= swr_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end
    assign h_dat_o  = rdat_q;
    assign h_ack_o  = ack_q;
    assign h_err_o  = err_q;
    assign h_busy_o = state_q != IDLE;
    assign s_rd_o   = srd_q;
    assign s_wr_o   = swr_q;
    assign s_dat_o  = wdat_q;
endmodule

// File: tb/tb_top_submap_decoder.sv
// tb_top_submap_decoder: randomized self-checking bench for top_submap_decoder against a transaction-level model
module tb_top_submap_decoder;
    localparam int NS = 5, AW = 5, DW = 32, TO = 255;
    logic clk_i = 1'b0, rst_i = 1'b1;
    logic [AW-1:0] h_adr_i = '0;
    logic [DW-1:0] h_dat_i = '0, h_dat_o, s_dat_o;
    logic h_wr_i = 1'b0, h_rd_i = 1'b0, h_ack_o, h_err_o, h_busy_o;
    logic [NS-1:0] s_wr_o, s_rd_o, s_ack_i = '0;
    logic [NS*DW-1:0] s_dat_i;
    logic [DW-1:0] slot_mem [NS];
    always #5 clk_i = ~clk_i;
    for (genvar g = 0; g < NS; g++) begin : g_slot
        assign s_dat_i[g*DW +: DW] = slot_mem[g];
    end
    top_submap_decoder #(.N_SLOTS(NS), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .h_adr_i(h_adr_i), .h_dat_i(h_dat_i), .h_wr_i(h_wr_i),
        .h_rd_i(h_rd_i), .h_dat_o(h_dat_o), .h_ack_o(h_ack_o), .h_err_o(h_err_o),
        .h_busy_o(h_busy_o), .s_wr_o(s_wr_o), .s_rd_o(s_rd_o), .s_dat_o(s_dat_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );
    int n_cmp = 0, n_bad = 0;
    logic [DW-1:0] exp_hdat = '0;
    int o_stb_n, o_stb_cyc, o_resp_cyc;
    logic [NS-1:0] o_rd, o_wr;
    logic [DW-1:0] o_sdat, o_hdat;
    logic o_ack, o_err, o_extra, o_busy_ok;

    // Drives one host access starting at the current negedge and records what the DUT did.
    task automatic run_txn(input logic [AW-1:0] adr, input logic rd, input logic wr,
                           input logic [DW-1:0] dat, input int dly, input logic [NS-1:0] noise,
                           input logic restb, input int bound);
        int k;
        k = int'(adr) >> 2;
        h_adr_i = adr; h_rd_i = rd; h_wr_i = wr; h_dat_i = dat; s_ack_i = '0;
        o_stb_n = 0; o_stb_cyc = -1; o_resp_cyc = -1; o_rd = '0; o_wr = '0; o_sdat = '0;
        o_hdat = '0; o_ack = 1'b0; o_err = 1'b0; o_busy_ok = 1'b1; o_extra = 1'b0;
        for (int c = 1; c <= bound; c++) begin
            @(negedge clk_i);
            if (s_rd_o != '0 || s_wr_o != '0) begin
                o_stb_n++; o_stb_cyc = c; o_rd |= s_rd_o; o_wr |= s_wr_o; o_sdat = s_dat_o;
            end
            if (!h_busy_o) o_busy_ok = 1'b0;
            h_rd_i = 1'b0; h_wr_i = 1'b0; s_ack_i = '0;
            if (h_ack_o || h_err_o) begin
                o_resp_cyc = c; o_ack = h_ack_o; o_err = h_err_o; o_hdat = h_dat_o;
                break;
            end
            if (restb && c == 2) begin h_adr_i = '0; h_rd_i = 1'b1; end
            if (dly >= 0 && o_stb_cyc > 0 && c == o_stb_cyc + dly) s_ack_i = NS'(1) << k;
            s_ack_i |= noise;
        end
        if (o_resp_cyc > 0) begin
            @(negedge clk_i);
            o_extra = h_ack_o | h_err_o | h_busy_o | (|s_rd_o) | (|s_wr_o);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        n_cmp++;
        if ({h_dat_o, h_ack_o, h_err_o, h_busy_o, s_wr_o, s_rd_o, s_dat_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs dat=%h ack=%b err=%b busy=%b wr=%b rd=%b sdat=%h required all 0",
                     h_dat_o, h_ack_o, h_err_o, h_busy_o, s_wr_o, s_rd_o, s_dat_o);
        end
        rst_i = 1'b0;
        exp_hdat = '0;
    endtask

    task automatic test_read();
        slot_mem[2] = 32'hA5A5_0002;
        run_txn(5'h08, 1'b1, 1'b0, $urandom, 3, '0, 1'b0, 20);
        exp_hdat = 32'hA5A5_0002;
        n_cmp++;
        if (o_rd !== 5'b00100 || o_wr !== '0 || o_stb_n != 1 || o_stb_cyc != 1) begin
            n_bad++;
            $display("FAIL read_strobe rd=%b wr=%b n=%0d cyc=%0d required rd=00100 wr=00000 n=1 cyc=1", o_rd, o_wr, o_stb_n, o_stb_cyc);
        end
        n_cmp++;
        if (o_resp_cyc != 5 || o_ack !== 1'b1 || o_err !== 1'b0) begin
            n_bad++;
            $display("FAIL read_resp cyc=%0d ack=%b err=%b required cyc=5 ack=1 err=0", o_resp_cyc, o_ack, o_err);
        end
        n_cmp++;
        if (o_hdat !== exp_hdat || o_extra || !o_busy_ok) begin
            n_bad++;
            $display("FAIL read_data dat=%h extra=%b busy_ok=%b required dat=%h extra=0 busy_ok=1", o_hdat, o_extra, o_busy_ok, exp_hdat);
        end
    endtask

    task automatic test_write();
        run_txn(5'h10, 1'b0, 1'b1, 32'h1234_5678, 0, '0, 1'b0, 20);
        n_cmp++;
        if (o_wr !== 5'b10000 || o_rd !== '0 || o_stb_n != 1 || o_sdat !== 32'h1234_5678) begin
            n_bad++;
            $display("FAIL write_strobe wr=%b rd=%b n=%0d sdat=%h required wr=10000 rd=00000 n=1 sdat=12345678", o_wr, o_rd, o_stb_n, o_sdat);
        end
        n_cmp++;
        if (o_resp_cyc != 2 || o_ack !== 1'b1 || o_err !== 1'b0 || o_hdat !== exp_hdat || o_extra) begin
            n_bad++;
            $display("FAIL write_resp cyc=%0d ack=%b err=%b dat=%h extra=%b required cyc=2 ack=1 err=0 dat=%h extra=0",
                     o_resp_cyc, o_ack, o_err, o_hdat, o_extra, exp_hdat);
        end
    endtask

    task automatic test_decode_err();
        logic [AW-1:0] adrs [4] = '{5'h14, 5'h18, 5'h1c, 5'h00};
        for (int i = 0; i < 4; i++) begin
            run_txn(adrs[i], 1'b1, i == 3, $urandom, 0, '0, 1'b0, 20);
            n_cmp++;
            if (o_stb_n != 0 || o_resp_cyc != 1 || o_err !== 1'b1 || o_ack !== 1'b0) begin
                n_bad++;
                $display("FAIL decode_err adr=%h n=%0d cyc=%0d err=%b ack=%b required n=0 cyc=1 err=1 ack=0", adrs[i], o_stb_n, o_resp_cyc, o_err, o_ack);
            end
            n_cmp++;
            if (o_hdat !== exp_hdat || o_extra) begin
                n_bad++;
                $display("FAIL decode_hold adr=%h dat=%h extra=%b required dat=%h extra=0", adrs[i], o_hdat, o_extra, exp_hdat);
            end
        end
    endtask

    task automatic test_ignore();
        slot_mem[0] = $urandom;
        slot_mem[1] = $urandom;
        run_txn(5'h04, 1'b1, 1'b0, $urandom, 4, 5'b00001, 1'b1, 20);
        exp_hdat = slot_mem[1];
        n_cmp++;
        if (o_stb_n != 1 || o_rd !== 5'b00010 || o_resp_cyc != 6 || o_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL ignore_pending n=%0d rd=%b cyc=%0d ack=%b required n=1 rd=00010 cyc=6 ack=1", o_stb_n, o_rd, o_resp_cyc, o_ack);
        end
        n_cmp++;
        if (o_hdat !== exp_hdat || o_extra) begin
            n_bad++;
            $display("FAIL ignore_data dat=%h extra=%b required dat=%h extra=0", o_hdat, o_extra, exp_hdat);
        end
    endtask

    task automatic test_timeout();
        slot_mem[3] = $urandom;
        run_txn(5'h0c, 1'b1, 1'b0, $urandom, -1, '0, 1'b0, 300);
        n_cmp++;
        if (o_stb_n != 1 || o_rd !== 5'b01000) begin
            n_bad++;
            $display("FAIL noack_strobe n=%0d rd=%b required n=1 rd=01000", o_stb_n, o_rd);
        end
`ifdef TOP_SUBMAP_DECODER_TIMEOUT_EN
        n_cmp++;
        if (o_resp_cyc != TO + 1 || o_err !== 1'b1 || o_ack !== 1'b0 || o_hdat !== exp_hdat || o_extra) begin
            n_bad++;
            $display("FAIL timeout_err cyc=%0d err=%b ack=%b dat=%h extra=%b required cyc=%0d err=1 ack=0 dat=%h extra=0",
                     o_resp_cyc, o_err, o_ack, o_hdat, o_extra, TO + 1, exp_hdat);
        end
        s_ack_i = 5'b01000;
        @(negedge clk_i);
        s_ack_i = '0;
        n_cmp++;
        if (h_ack_o || h_err_o || h_busy_o) begin
            n_bad++;
            $display("FAIL timeout_late_ack ack=%b err=%b busy=%b required all 0", h_ack_o, h_err_o, h_busy_o);
        end
        run_txn(5'h0c, 1'b1, 1'b0, $urandom, TO - 1, '0, 1'b0, 300);
        exp_hdat = slot_mem[3];
        n_cmp++;
        if (o_resp_cyc != TO + 1 || o_ack !== 1'b1 || o_err !== 1'b0 || o_hdat !== exp_hdat) begin
            n_bad++;
            $display("FAIL timeout_tie cyc=%0d ack=%b err=%b dat=%h required cyc=%0d ack=1 err=0 dat=%h",
                     o_resp_cyc, o_ack, o_err, o_hdat, TO + 1, exp_hdat);
        end
`else
        n_cmp++;
        if (o_resp_cyc != -1 || !o_busy_ok) begin
            n_bad++;
            $display("FAIL noack_wait cyc=%0d busy_ok=%b required cyc=-1 busy_ok=1", o_resp_cyc, o_busy_ok);
        end
        s_ack_i = 5'b01000;
        @(negedge clk_i);
        s_ack_i = '0;
        exp_hdat = slot_mem[3];
        n_cmp++;
        if (h_ack_o !== 1'b1 || h_err_o !== 1'b0 || h_dat_o !== exp_hdat) begin
            n_bad++;
            $display("FAIL noack_release ack=%b err=%b dat=%h required ack=1 err=0 dat=%h", h_ack_o, h_err_o, h_dat_o, exp_hdat);
        end
        @(negedge clk_i);
`endif
    endtask

    task automatic test_reset_mid();
        slot_mem[1] = $urandom;
        h_adr_i = 5'h08; h_rd_i = 1'b1;
        @(negedge clk_i);
        h_rd_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        s_ack_i = 5'b00100;
        exp_hdat = '0;
        n_cmp++;
        if ({h_dat_o, h_ack_o, h_err_o, h_busy_o, s_wr_o, s_rd_o, s_dat_o} !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs dat=%h ack=%b err=%b busy=%b wr=%b rd=%b required all 0",
                     h_dat_o, h_ack_o, h_err_o, h_busy_o, s_wr_o, s_rd_o);
        end
        @(negedge clk_i);
        s_ack_i = '0;
        n_cmp++;
        if (h_ack_o || h_err_o || h_busy_o) begin
            n_bad++;
            $display("FAIL midreset_late_ack ack=%b err=%b busy=%b required all 0", h_ack_o, h_err_o, h_busy_o);
        end
        run_txn(5'h04, 1'b1, 1'b0, $urandom, 1, '0, 1'b0, 20);
        exp_hdat = slot_mem[1];
        n_cmp++;
        if (o_resp_cyc != 3 || o_ack !== 1'b1 || o_rd !== 5'b00010 || o_hdat !== exp_hdat) begin
            n_bad++;
            $display("FAIL midreset_fresh cyc=%0d ack=%b rd=%b dat=%h required cyc=3 ack=1 rd=00010 dat=%h",
                     o_resp_cyc, o_ack, o_rd, o_hdat, exp_hdat);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 60; t++) begin
            logic [AW-1:0] adr;
            logic [DW-1:0] dat;
            logic [NS-1:0] noise, exp_rd, exp_wr;
            logic rd, wr, good;
            int sel, k, dly;
            adr = AW'($urandom_range(0, 31));
            sel = $urandom_range(0, 8);
            rd = sel <= 4;
            wr = sel == 0 || sel > 4;
            dat = $urandom;
            dly = $urandom_range(0, 5);
            k = int'(adr) >> 2;
            for (int i = 0; i < NS; i++) slot_mem[i] = $urandom;
            noise = NS'($urandom) & ~(NS'(1) << k);
            good = (rd != wr) && k < NS;
            exp_rd = good && rd ? NS'(1) << k : '0;
            exp_wr = good && wr ? NS'(1) << k : '0;
            run_txn(adr, rd, wr, dat, dly, noise, 1'b0, 20);
            if (good && rd) exp_hdat = slot_mem[k];
            n_cmp++;
            if (o_resp_cyc != (good ? dly + 2 : 1) || o_ack !== good || o_err !== !good) begin
                n_bad++;
                $display("FAIL rand_resp t=%0d adr=%h rd=%b wr=%b cyc=%0d ack=%b err=%b required cyc=%0d ack=%b err=%b",
                         t, adr, rd, wr, o_resp_cyc, o_ack, o_err, good ? dly + 2 : 1, good, !good);
            end
            n_cmp++;
            if (o_rd !== exp_rd || o_wr !== exp_wr || o_stb_n != (good ? 1 : 0) || (good && wr && o_sdat !== dat)) begin
                n_bad++;
                $display("FAIL rand_strobe t=%0d rd=%b wr=%b n=%0d sdat=%h required rd=%b wr=%b sdat=%h",
                         t, o_rd, o_wr, o_stb_n, o_sdat, exp_rd, exp_wr, dat);
            end
            n_cmp++;
            if (o_hdat !== exp_hdat || o_extra) begin
                n_bad++;
                $display("FAIL rand_data t=%0d dat=%h extra=%b required dat=%h extra=0", t, o_hdat, o_extra, exp_hdat);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NS; i++) slot_mem[i] = '0;
        test_reset();
        test_read();
        test_write();
        test_decode_err();
        test_ignore();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end
endmodule
